// File: rtl/fir_coef_ctrl.sv
// rtl/fir_coef_ctrl.sv - double-buffered FIR coefficient controller with post-swap flush
module fir_coef_ctrl #(
  parameter int BITWIDTH = 16,
  parameter int N        = 16,
  parameter bit FLUSH_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [BITWIDTH-1:0]   cfg_data,
  input  logic                  cfg_last,
  input  logic                  commit,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BITWIDTH-1:0]   s_data,
  output logic                  fir_enable,
  output logic [BITWIDTH-1:0]   fir_in,
  output logic [N*BITWIDTH-1:0] coeffs,
  input  logic                  fir_oen,
  output logic                  out_valid,
  output logic                  active_bank,
  output logic                  swap_done,
  output logic                  cfg_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARMED = 3'd2,
    ST_SWAP  = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  state_t state, state_nx;

  // Two tap banks; the one not selected by active_bank is the shadow being loaded.
  logic [BITWIDTH-1:0] bank0 [N];
  logic [BITWIDTH-1:0] bank1 [N];

  logic [IW-1:0] wr_idx;
  logic [IW-1:0] flush_cnt;
  logic          cfg_fire;
  logic          at_end;
  logic          set_ok;
  logic          set_bad;

  // Handshakes, sample/flush mux, output qualification and next-state selection
  always_comb begin
    state_nx   = state;
    s_ready    = 1'b0;
    cfg_ready  = 1'b0;
    swap_done  = 1'b0;
    case (state)
      ST_RUN, ST_LOAD: begin
        s_ready   = 1'b1;
        cfg_ready = 1'b1;
      end
      ST_ARMED: s_ready = 1'b1;
      default:  ;
    endcase

    cfg_fire = cfg_valid & cfg_ready;
    at_end   = (wr_idx == LAST_IDX);
    // A set is good only when cfg_last lands exactly on the final tap.
    set_ok   = cfg_fire & cfg_last & at_end;
    set_bad  = cfg_fire & (cfg_last ^ at_end);

    // During flush the FIR is clocked with zeros regardless of the upstream source.
    fir_enable = (state == ST_FLUSH) | (s_valid & s_ready);
    fir_in     = (state == ST_FLUSH) ? '0 : s_data;
    out_valid  = fir_oen & (state != ST_FLUSH);

    case (state)
      ST_RUN, ST_LOAD: begin
        if (set_ok)        state_nx = ST_ARMED;
        else if (set_bad)  state_nx = ST_RUN;
        else if (cfg_fire) state_nx = ST_LOAD;
      end
      ST_ARMED: begin
        if (commit) state_nx = ST_SWAP;
      end
      ST_SWAP: begin
        if (FLUSH_EN) begin
          state_nx = ST_FLUSH;
        end else begin
          state_nx  = ST_RUN;
          swap_done = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) begin
          state_nx  = ST_RUN;
          swap_done = 1'b1;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // State register, write index, flush counter, bank select and sticky error
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_RUN;
      wr_idx      <= '0;
      flush_cnt   <= '0;
      active_bank <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (cfg_fire) begin
        if (cfg_last || at_end) wr_idx <= '0;
        else                    wr_idx <= wr_idx + IW'(1);
      end
      if (set_bad) cfg_err <= 1'b1;
      if (state == ST_SWAP) begin
        active_bank <= ~active_bank;
        flush_cnt   <= LAST_IDX;
      end else if (state == ST_FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - IW'(1);
      end
    end
  end

  // Shadow bank write port; a reset discards any partially loaded set
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < N; k++) begin
        bank0[k] <= '0;
        bank1[k] <= '0;
      end
    end else if (cfg_fire) begin
      if (active_bank) bank0[wr_idx] <= cfg_data;
      else             bank1[wr_idx] <= cfg_data;
    end
  end

  // Registered coefficient output, updated only at the end of the SWAP cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      coeffs <= '0;
    end else if (state == ST_SWAP) begin
      for (int k = 0; k < N; k++) begin
        coeffs[k*BITWIDTH +: BITWIDTH] <= active_bank ? bank0[k] : bank1[k];
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb/tb_fir_coef_ctrl.sv - directed self-checking bench for fir_coef_ctrl
module tb_fir_coef_ctrl;

  localparam int BW = 16;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Flushing instance
  logic          cfg_valid = 0, cfg_last = 0, commit = 0, s_valid = 0;
  logic [BW-1:0] cfg_data = '0, s_data = '0;
  logic          cfg_ready, s_ready, fir_enable, out_valid, active_bank, swap_done, cfg_err;
  logic [BW-1:0] fir_in;
  logic [N*BW-1:0] coeffs;
  logic          fir_oen;

  // Non-flushing instance
  logic          n_cfg_valid = 0, n_cfg_last = 0, n_commit = 0, n_s_valid = 0, n_fir_oen = 0;
  logic [BW-1:0] n_cfg_data = '0, n_s_data = '0;
  logic          n_cfg_ready, n_s_ready, n_fir_enable, n_out_valid, n_active_bank, n_swap_done, n_cfg_err;
  logic [BW-1:0] n_fir_in;
  logic [N*BW-1:0] n_coeffs;

  fir_coef_ctrl #(.BITWIDTH(BW), .N(N), .FLUSH_EN(1'b1)) u_dut (
    .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .commit(commit), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .fir_enable(fir_enable), .fir_in(fir_in),
    .coeffs(coeffs), .fir_oen(fir_oen), .out_valid(out_valid), .active_bank(active_bank),
    .swap_done(swap_done), .cfg_err(cfg_err)
  );

  fir_coef_ctrl #(.BITWIDTH(BW), .N(N), .FLUSH_EN(1'b0)) u_nf (
    .clk(clk), .resetn(resetn), .cfg_valid(n_cfg_valid), .cfg_ready(n_cfg_ready),
    .cfg_data(n_cfg_data), .cfg_last(n_cfg_last), .commit(n_commit), .s_valid(n_s_valid),
    .s_ready(n_s_ready), .s_data(n_s_data), .fir_enable(n_fir_enable), .fir_in(n_fir_in),
    .coeffs(n_coeffs), .fir_oen(n_fir_oen), .out_valid(n_out_valid), .active_bank(n_active_bank),
    .swap_done(n_swap_done), .cfg_err(n_cfg_err)
  );

  // Behavioural N-tap FIR with one cycle of output latency
  logic signed [BW-1:0] dl [N];
  logic signed [31:0]   fir_out;
  logic signed [31:0]   acc;

  always_comb begin
    acc = 32'($signed(coeffs[0 +: BW])) * 32'($signed(fir_in));
    for (int k = 1; k < N; k++)
      acc = acc + 32'($signed(coeffs[k*BW +: BW])) * 32'(dl[k-1]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < N; k++) dl[k] <= '0;
      fir_out <= '0;
      fir_oen <= 1'b0;
    end else begin
      fir_oen <= fir_enable;
      if (fir_enable) begin
        fir_out <= acc;
        dl[0]   <= fir_in;
        for (int k = 1; k < N; k++) dl[k] <= dl[k-1];
      end
    end
  end

  int outq [$];
  always @(negedge clk) if (out_valid) outq.push_back(fir_out);

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_taps(input int base, input int step);
    for (int k = 0; k < N; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = BW'(base + step * k);
      cfg_last  = (k == N - 1);
      tick();
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic push_impulse;
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = (i == 0) ? BW'(1) : BW'(0);
      tick();
    end
    s_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick(); tick();
    total_cnt++; if (coeffs !== '0) $display("FAIL reset_coeffs got %h want 0", coeffs); else pass_cnt++;
    total_cnt++; if (active_bank !== 1'b0) $display("FAIL reset_bank got %b want 0", active_bank); else pass_cnt++;
    total_cnt++; if (swap_done !== 1'b0 || cfg_err !== 1'b0) $display("FAIL reset_flags got done=%b err=%b want 0/0", swap_done, cfg_err); else pass_cnt++;
    total_cnt++; if (cfg_ready !== 1'b1 || s_ready !== 1'b1) $display("FAIL reset_ready got cfg=%b s=%b want 1/1", cfg_ready, s_ready); else pass_cnt++;
    resetn = 1'b1;
    tick();
    outq.delete();
    push_impulse();
    total_cnt++; if (outq.size() != N) $display("FAIL zero_bank_count got %0d want %0d", outq.size(), N); else pass_cnt++;
    for (int i = 0; i < outq.size(); i++) begin
      total_cnt++; if (outq[i] !== 0) $display("FAIL zero_bank_out[%0d] got %0d want 0", i, outq[i]); else pass_cnt++;
    end
  endtask

  task automatic test_load_swap;
    int n_flush, n_lo, n_done, done_at;
    load_taps(1, 1);
    #1;
    total_cnt++; if (cfg_ready !== 1'b0 || s_ready !== 1'b1) $display("FAIL armed_ready got cfg=%b s=%b want 0/1", cfg_ready, s_ready); else pass_cnt++;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    #1;
    total_cnt++; if (active_bank !== 1'b0 || coeffs !== '0) $display("FAIL swap_cycle_bank got bank=%b c0=%0d want 0/0", active_bank, coeffs[0 +: BW]); else pass_cnt++;
    n_flush = 0; n_lo = 0; n_done = 0; done_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (!s_ready) n_lo++;
      if (!s_ready && fir_enable && fir_in == '0) n_flush++;
      if (swap_done) begin n_done++; done_at = n_flush; end
      tick();
    end
    total_cnt++; if (n_flush != N) $display("FAIL flush_cycles got %0d want %0d", n_flush, N); else pass_cnt++;
    total_cnt++; if (n_lo != N + 1) $display("FAIL sready_low got %0d want %0d", n_lo, N + 1); else pass_cnt++;
    total_cnt++; if (n_done != 1 || done_at != N) $display("FAIL swap_done got n=%0d at=%0d want 1 at %0d", n_done, done_at, N); else pass_cnt++;
    total_cnt++; if (active_bank !== 1'b1) $display("FAIL bank_after_swap got %b want 1", active_bank); else pass_cnt++;
    total_cnt++; if (coeffs[15*BW +: BW] !== BW'(16)) $display("FAIL tap15 got %0d want 16", coeffs[15*BW +: BW]); else pass_cnt++;
    outq.delete();
    push_impulse();
    total_cnt++; if (outq.size() != N) $display("FAIL impulse_count got %0d want %0d", outq.size(), N); else pass_cnt++;
    for (int i = 0; i < outq.size(); i++) begin
      total_cnt++; if (outq[i] !== i + 1) $display("FAIL impulse_out[%0d] got %0d want %0d", i, outq[i], i + 1); else pass_cnt++;
    end
  endtask

  task automatic test_cfg_err;
    total_cnt++; if (cfg_err !== 1'b0) $display("FAIL err_before got %b want 0", cfg_err); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      cfg_valid = 1'b1; cfg_data = BW'(100 + k); cfg_last = (k == 4);
      tick();
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    #1;
    total_cnt++; if (cfg_err !== 1'b1) $display("FAIL short_set_err got %b want 1", cfg_err); else pass_cnt++;
    total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL err_state_ready got %b want 1", cfg_ready); else pass_cnt++;
    commit = 1'b1;
    tick(); tick(); tick();
    commit = 1'b0;
    #1;
    total_cnt++; if (s_ready !== 1'b1 || fir_enable !== 1'b0) $display("FAIL commit_ignored got s_ready=%b en=%b want 1/0", s_ready, fir_enable); else pass_cnt++;
    total_cnt++; if (active_bank !== 1'b1 || coeffs[0 +: BW] !== BW'(1)) $display("FAIL coeffs_kept got bank=%b c0=%0d want 1/1", active_bank, coeffs[0 +: BW]); else pass_cnt++;
    total_cnt++; if (cfg_err !== 1'b1) $display("FAIL err_sticky got %b want 1", cfg_err); else pass_cnt++;
  endtask

  task automatic test_armed_block;
    int bad;
    bit seen, after_ok;
    load_taps(16, -1);
    cfg_valid = 1'b1; cfg_data = BW'(7); cfg_last = 1'b0;
    outq.delete();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = (i == 0) ? BW'(2) : BW'(0);
      #1;
      if (cfg_ready) bad++;
      tick();
    end
    s_valid = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    total_cnt++; if (outq.size() != 3) $display("FAIL old_taps_count got %0d want 3", outq.size()); else pass_cnt++;
    if (outq.size() == 3) begin
      total_cnt++; if (outq[0] !== 2 || outq[1] !== 4 || outq[2] !== 6) $display("FAIL old_taps_out got %0d,%0d,%0d want 2,4,6", outq[0], outq[1], outq[2]); else pass_cnt++;
    end
    seen = 0; after_ok = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (seen) begin after_ok = cfg_ready; break; end
      if (cfg_ready) bad++;
      if (swap_done) seen = 1;
      tick();
    end
    cfg_valid = 1'b0;
    total_cnt++; if (bad != 0) $display("FAIL armed_cfg_ready got %0d ready cycles want 0", bad); else pass_cnt++;
    total_cnt++; if (!seen || !after_ok) $display("FAIL ready_after_done got seen=%b ready=%b want 1/1", seen, after_ok); else pass_cnt++;
    total_cnt++; if (active_bank !== 1'b0 || coeffs[0 +: BW] !== BW'(16)) $display("FAIL second_swap got bank=%b c0=%0d want 0/16", active_bank, coeffs[0 +: BW]); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_in_flush;
    int n_done;
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    load_taps(1, 1);
    commit = 1'b1; tick(); commit = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    total_cnt++; if (s_ready !== 1'b0 || fir_enable !== 1'b1) $display("FAIL in_flush got s_ready=%b en=%b want 0/1", s_ready, fir_enable); else pass_cnt++;
    resetn = 1'b0;
    tick();
    total_cnt++; if (active_bank !== 1'b0 || coeffs !== '0) $display("FAIL rst_flush_bank got bank=%b coeffs=%h want 0/0", active_bank, coeffs); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b1 || cfg_ready !== 1'b1 || fir_enable !== 1'b0 || swap_done !== 1'b0) $display("FAIL rst_flush_out got s=%b c=%b en=%b done=%b want 1/1/0/0", s_ready, cfg_ready, fir_enable, swap_done); else pass_cnt++;
    resetn = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (swap_done) n_done++;
      tick();
    end
    total_cnt++; if (n_done != 0) $display("FAIL rst_no_done got %0d want 0", n_done); else pass_cnt++;
  endtask

  task automatic test_no_flush;
    for (int k = 0; k < N; k++) begin
      n_cfg_valid = 1'b1; n_cfg_data = BW'(10 + k); n_cfg_last = (k == N - 1);
      tick();
    end
    n_cfg_valid = 1'b0; n_cfg_last = 1'b0;
    n_commit = 1'b1;
    tick();
    n_commit = 1'b0;
    #1;
    total_cnt++; if (n_s_ready !== 1'b0 || n_swap_done !== 1'b1) $display("FAIL nf_swap got s_ready=%b done=%b want 0/1", n_s_ready, n_swap_done); else pass_cnt++;
    tick();
    total_cnt++; if (n_s_ready !== 1'b1 || n_swap_done !== 1'b0) $display("FAIL nf_after got s_ready=%b done=%b want 1/0", n_s_ready, n_swap_done); else pass_cnt++;
    total_cnt++; if (n_active_bank !== 1'b1 || n_coeffs[3*BW +: BW] !== BW'(13)) $display("FAIL nf_bank got bank=%b c3=%0d want 1/13", n_active_bank, n_coeffs[3*BW +: BW]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_swap();
    test_cfg_err();
    test_armed_block();
    test_reset_in_flush();
    test_no_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
